// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game judge and score counter.
// The Inp codes below are also decoded by the score counter.
package game_pkg;

  localparam logic [0:0] LANE_IDLE = 1'b0;
  localparam logic [0:0] LANE_OPEN = 1'b1;

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_L0   = 2'b01;
  localparam logic [1:0] HIT_L1   = 2'b10;
  localparam logic [1:0] HIT_BOTH = 2'b11;

  localparam logic [7:0] COMBO_MAX = 8'd255;

  function automatic logic [1:0] inp_code(input logic h0, input logic h1);
    logic [1:0] code;
    case ({h1, h0})
      2'b00:   code = HIT_NONE;
      2'b01:   code = HIT_L0;
      2'b10:   code = HIT_L1;
      default: code = HIT_BOTH;
    endcase
    return code;
  endfunction

  // Widen before adding so that 255 + 1 clamps instead of wrapping to 0.
  function automatic logic [7:0] combo_inc(input logic [7:0] c);
    logic [8:0] sum;
    sum = {1'b0, c} + 9'd1;
    if (sum > {1'b0, COMBO_MAX}) return COMBO_MAX;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/lane_judge.sv
// One lane of the timing judge: button edge detect, IDLE/OPEN FSM and
// the hit-window down-counter. Lane results are combinational.
module lane_judge
  import game_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CW     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic note_in,
  output logic lane_hit,
  output logic lane_miss
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(WINDOW - 1);

  logic          r_btn_q;
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;

  logic          w_rise;
  logic          w_cnt_zero;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_rise     = btn & ~r_btn_q;
  assign w_cnt_zero = (r_cnt == '0);

  // A note arriving on an open lane resolves the old note first, then reopens.
  always_comb begin
    lane_hit    = 1'b0;
    lane_miss   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LANE_IDLE: begin
        if (note_in) begin
          w_state_nxt = LANE_OPEN;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      default: begin
        if (w_rise) begin
          lane_hit = 1'b1;
        end else if (note_in || w_cnt_zero) begin
          lane_miss = 1'b1;
        end
        if (note_in) begin
          w_state_nxt = LANE_OPEN;
          w_cnt_nxt   = CNT_LOAD;
        end else if (w_rise || w_cnt_zero) begin
          w_state_nxt = LANE_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q <= 1'b0;
      r_state <= LANE_IDLE;
      r_cnt   <= '0;
    end else begin
      r_btn_q <= btn;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Two-lane timing judge feeding the score counter: registered hit code,
// miss pulse, saturating combo and best-combo tracking.
module hit_judge
  import game_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CW     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic [1:0] note_in,
  output logic [1:0] hit,
  output logic       miss,
  output logic [7:0] combo,
  output logic [7:0] max_combo
);

  logic       w_hit0;
  logic       w_hit1;
  logic       w_miss0;
  logic       w_miss1;
  logic       w_any_hit;
  logic       w_any_miss;
  logic [7:0] w_combo_nxt;

  logic [1:0] r_hit;
  logic       r_miss;
  logic [7:0] r_combo;
  logic [7:0] r_max_combo;

  lane_judge #(.WINDOW(WINDOW), .CW(CW)) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn[0]),
    .note_in   (note_in[0]),
    .lane_hit  (w_hit0),
    .lane_miss (w_miss0)
  );

  lane_judge #(.WINDOW(WINDOW), .CW(CW)) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn[1]),
    .note_in   (note_in[1]),
    .lane_hit  (w_hit1),
    .lane_miss (w_miss1)
  );

  assign w_any_hit  = w_hit0 | w_hit1;
  assign w_any_miss = w_miss0 | w_miss1;

  // A miss on either lane breaks the combo even if the other lane hit.
  always_comb begin
    w_combo_nxt = r_combo;
    if (w_any_miss) begin
      w_combo_nxt = '0;
    end else if (w_any_hit) begin
      w_combo_nxt = combo_inc(r_combo);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit       <= HIT_NONE;
      r_miss      <= 1'b0;
      r_combo     <= '0;
      r_max_combo <= '0;
    end else begin
      r_hit   <= inp_code(w_hit0, w_hit1);
      r_miss  <= w_any_miss;
      r_combo <= w_combo_nxt;
      if (w_combo_nxt > r_max_combo) begin
        r_max_combo <= w_combo_nxt;
      end
    end
  end

  assign hit       = r_hit;
  assign miss      = r_miss;
  assign combo     = r_combo;
  assign max_combo = r_max_combo;

endmodule
